// File: rtl/rs_simple_pkg.sv
// rtl/rs_simple_pkg.sv - shared widths, entry/CDB layouts and wakeup helper for rs_simple
package rs_simple_pkg;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int ENTRY_W = 2 * (XLEN + 1) + TAG_W + 5;
  localparam int CDB_W   = XLEN + TAG_W;

  // Entry field offsets, shared with the ex_simple wrapper
  localparam int AOP_LSB   = 0;
  localparam int RD_LSB    = 5;
  localparam int RS1_V_BIT = 10;
  localparam int RS1_LSB   = 11;
  localparam int RS2_V_BIT = 43;
  localparam int RS2_LSB   = 44;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4
  } alu_op_e;

  // Operand field carries the value when _v=1, else the producer tag in its low bits
  typedef struct packed {
    logic [XLEN-1:0] rs2_vt;
    logic            rs2_v;
    logic [XLEN-1:0] rs1_vt;
    logic            rs1_v;
    logic [4:0]      rd;
    logic [4:0]      aluop;
  } entry_t;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] tag;
  } cdb_t;

  // Apply one CDB broadcast to both operands of an entry; waiting operands with a
  // matching producer tag become valid and take the broadcast value.
  function automatic entry_t capture(input entry_t e, input logic cdb_valid, input cdb_t c);
    entry_t r;
    r = e;
    if (cdb_valid && !e.rs1_v && (e.rs1_vt[TAG_W-1:0] == c.tag)) begin
      r.rs1_v  = 1'b1;
      r.rs1_vt = c.value;
    end
    if (cdb_valid && !e.rs2_v && (e.rs2_vt[TAG_W-1:0] == c.tag)) begin
      r.rs2_v  = 1'b1;
      r.rs2_vt = c.value;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_simple_if.sv
// rtl/rs_simple_if.sv - dispatch, CDB, issue and entry-presentation bundle (flush when RS_SIMPLE_FLUSH_EN)
interface rs_simple_if;
  import rs_simple_pkg::*;

  logic               disp0_valid;
  logic [ENTRY_W-1:0] disp0_entry;
  logic               disp1_valid;
  logic [ENTRY_W-1:0] disp1_entry;
  logic [1:0]         disp_free;
  logic               cdb_valid;
  logic [CDB_W-1:0]   cdb_data;
  logic [ENTRY_W-1:0] rs_simple_0;
  logic [ENTRY_W-1:0] rs_simple_1;
  logic               selector;
  logic               simple_0_issue;
  logic               simple_1_issue;
`ifdef RS_SIMPLE_FLUSH_EN
  logic               flush;
`endif

  // Dispatch/CDB/wrapper side
  modport master (
`ifdef RS_SIMPLE_FLUSH_EN
    output flush,
`endif
    output disp0_valid, disp0_entry, disp1_valid, disp1_entry,
    output cdb_valid, cdb_data, simple_0_issue, simple_1_issue,
    input  disp_free, rs_simple_0, rs_simple_1, selector
  );

  // Reservation station side
  modport slave (
`ifdef RS_SIMPLE_FLUSH_EN
    input  flush,
`endif
    input  disp0_valid, disp0_entry, disp1_valid, disp1_entry,
    input  cdb_valid, cdb_data, simple_0_issue, simple_1_issue,
    output disp_free, rs_simple_0, rs_simple_1, selector
  );

endinterface

// File: rtl/rs_simple_entry.sv
// rtl/rs_simple_entry.sv - one reservation-station slot: busy flag, write port, operand wakeup, issue clear
module rs_simple_entry
  import rs_simple_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   wr_en,
  input  entry_t wr_data,
  input  logic   issue,
  input  logic   cdb_valid,
  input  cdb_t   cdb,
  output logic   busy,
  output entry_t data
);

  logic   busy_q;
  entry_t data_q;
  entry_t data_woken;
  entry_t wr_woken;

  // Held entry and incoming entry both see the current CDB so no broadcast is missed
  always_comb begin
    data_woken = capture(data_q, cdb_valid, cdb);
    wr_woken   = capture(wr_data, cdb_valid, cdb);
  end

  // Slot state: clear beats everything, a write only targets a free slot, issue beats wakeup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      data_q <= '0;
    end else if (clear) begin
      busy_q <= 1'b0;
    end else if (wr_en) begin
      busy_q <= 1'b1;
      data_q <= wr_woken;
    end else if (issue) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      data_q <= data_woken;
    end
  end

  assign busy = busy_q;
  assign data = busy_q ? data_q : '0;

endmodule

// File: rtl/rs_simple.sv
// rtl/rs_simple.sv - two-entry reservation station for the simple ALU; optional flush via RS_SIMPLE_FLUSH_EN
module rs_simple
  import rs_simple_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  rs_simple_if.slave bus
);

  logic [1:0] busy;
  logic [1:0] busy_nxt;
  logic       wr0;
  logic       wr1;
  entry_t     wd0;
  entry_t     wd1;
  entry_t     disp0;
  entry_t     disp1;
  entry_t     out0;
  entry_t     out1;
  cdb_t       cdb;
  logic       flush_i;
  logic       sel_q;
  logic       sel_nxt;

`ifdef RS_SIMPLE_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  assign disp0 = bus.disp0_entry;
  assign disp1 = bus.disp1_entry;
  assign cdb   = bus.cdb_data;

  // Allocation against registered busy bits: slot 0 first into the lowest free entry,
  // slot 1 into whatever free entry remains; slots with no free entry are dropped
  always_comb begin
    wr0 = 1'b0;
    wr1 = 1'b0;
    wd0 = disp0;
    wd1 = disp0;
    if (bus.disp0_valid) begin
      if (!busy[0]) begin
        wr0 = 1'b1;
        wd0 = disp0;
      end else if (!busy[1]) begin
        wr1 = 1'b1;
        wd1 = disp0;
      end
    end
    if (bus.disp1_valid) begin
      if (!busy[0] && !wr0) begin
        wr0 = 1'b1;
        wd0 = disp1;
      end else if (!busy[1] && !wr1) begin
        wr1 = 1'b1;
        wd1 = disp1;
      end
    end
  end

  rs_simple_entry u_entry0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .wr_en     (wr0),
    .wr_data   (wd0),
    .issue     (bus.simple_0_issue),
    .cdb_valid (bus.cdb_valid),
    .cdb       (cdb),
    .busy      (busy[0]),
    .data      (out0)
  );

  rs_simple_entry u_entry1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush_i),
    .wr_en     (wr1),
    .wr_data   (wd1),
    .issue     (bus.simple_1_issue),
    .cdb_valid (bus.cdb_valid),
    .cdb       (cdb),
    .busy      (busy[1]),
    .data      (out1)
  );

  // Busy bits as they will be after this edge, used only to steer the age selector
  always_comb begin
    busy_nxt[0] = wr0 | (busy[0] & ~bus.simple_0_issue);
    busy_nxt[1] = wr1 | (busy[1] & ~bus.simple_1_issue);
    if (flush_i) begin
      busy_nxt = 2'b00;
    end
  end

  // Age selector: a lone entry is selected; a newcomer is younger than a survivor;
  // a dual dispatch into an empty station leaves entry 0 (slot 0) older
  always_comb begin
    sel_nxt = sel_q;
    case (busy_nxt)
      2'b00:   sel_nxt = 1'b0;
      2'b01:   sel_nxt = 1'b1;
      2'b10:   sel_nxt = 1'b0;
      default: sel_nxt = (busy == 2'b11) ? sel_q : ~busy[1];
    endcase
  end

  // Selector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel_nxt;
    end
  end

  assign bus.rs_simple_0 = out0;
  assign bus.rs_simple_1 = out1;
  assign bus.selector    = sel_q;
  assign bus.disp_free   = (busy == 2'b11) ? 2'd0 : ((busy == 2'b00) ? 2'd2 : 2'd1);

`ifdef RS_SIMPLE_ASSERT_EN
  logic [1:0] disp_cnt;
  assign disp_cnt = {1'b0, bus.disp0_valid} + {1'b0, bus.disp1_valid};

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    flush_i || (disp_cnt <= bus.disp_free));
  a_issue0_busy: assert property (@(posedge clk) disable iff (!rst_n)
    flush_i || !bus.simple_0_issue || busy[0]);
  a_issue1_busy: assert property (@(posedge clk) disable iff (!rst_n)
    flush_i || !bus.simple_1_issue || busy[1]);
`endif

endmodule

// File: tb/tb_rs_simple.sv
// tb/tb_rs_simple.sv - randomized and directed bench for rs_simple against an age-stamped slot model
module tb_rs_simple;
  import rs_simple_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rs_simple_if bus();

  rs_simple dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: per-slot occupancy, contents and allocation stamp (smaller = older)
  logic   m_busy[2];
  entry_t m_ent[2];
  int     m_age[2];
  logic   n_busy[2];
  entry_t n_ent[2];
  int     n_age[2];
  int     age_cnt = 0;
  entry_t ent_c;

  task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic entry_t wake(input entry_t e, input logic v, input cdb_t c);
    entry_t r;
    r = e;
    if (v && !r.rs1_v && ((r.rs1_vt & 32'h1f) == 32'(c.tag))) begin
      r.rs1_v = 1'b1; r.rs1_vt = c.value;
    end
    if (v && !r.rs2_v && ((r.rs2_vt & 32'h1f) == 32'(c.tag))) begin
      r.rs2_v = 1'b1; r.rs2_vt = c.value;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_ent[i] = '0; m_age[i] = 0;
    end
  endtask

  task automatic model_predict();
    int     slots[$];
    int     k;
    logic   fl;
    cdb_t   c;
    entry_t d0, d1;
    c  = bus.cdb_data;
    d0 = bus.disp0_entry;
    d1 = bus.disp1_entry;
    fl = 1'b0;
`ifdef RS_SIMPLE_FLUSH_EN
    fl = bus.flush;
`endif
    for (int i = 0; i < 2; i++) begin
      n_busy[i] = m_busy[i]; n_ent[i] = m_ent[i]; n_age[i] = m_age[i];
    end
    if (fl) begin
      n_busy[0] = 1'b0; n_busy[1] = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++) if (m_busy[i]) n_ent[i] = wake(m_ent[i], bus.cdb_valid, c);
    if (bus.simple_0_issue) n_busy[0] = 1'b0;
    if (bus.simple_1_issue) n_busy[1] = 1'b0;
    for (int i = 0; i < 2; i++) if (!m_busy[i]) slots.push_back(i);
    if (bus.disp0_valid && slots.size() > 0) begin
      k = slots.pop_front();
      n_busy[k] = 1'b1; n_ent[k] = wake(d0, bus.cdb_valid, c); n_age[k] = age_cnt++;
    end
    if (bus.disp1_valid && slots.size() > 0) begin
      k = slots.pop_front();
      n_busy[k] = 1'b1; n_ent[k] = wake(d1, bus.cdb_valid, c); n_age[k] = age_cnt++;
    end
  endtask

  task automatic compare();
    logic [ENTRY_W-1:0] e0, e1;
    int   nfree;
    logic esel;
    e0    = m_busy[0] ? m_ent[0] : '0;
    e1    = m_busy[1] ? m_ent[1] : '0;
    nfree = 2 - int'(m_busy[0]) - int'(m_busy[1]);
    esel  = (m_busy[0] && m_busy[1]) ? (m_age[0] < m_age[1]) : m_busy[0];
    chk("rs_simple_0", bus.rs_simple_0, e0);
    chk("rs_simple_1", bus.rs_simple_1, e1);
    chk("disp_free", ENTRY_W'(bus.disp_free), ENTRY_W'(nfree));
    chk("selector", ENTRY_W'(bus.selector), ENTRY_W'(esel));
  endtask

  task automatic cycle();
    model_predict();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = n_busy[i]; m_ent[i] = n_ent[i]; m_age[i] = n_age[i];
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    bus.disp0_valid = 1'b0; bus.disp0_entry = '0;
    bus.disp1_valid = 1'b0; bus.disp1_entry = '0;
    bus.cdb_valid = 1'b0; bus.cdb_data = '0;
    bus.simple_0_issue = 1'b0; bus.simple_1_issue = 1'b0;
`ifdef RS_SIMPLE_FLUSH_EN
    bus.flush = 1'b0;
`endif
  endtask

  function automatic entry_t mk(input logic v1, input logic [31:0] f1, input logic v2,
                                input logic [31:0] f2, input logic [4:0] rd, input logic [4:0] op);
    entry_t e;
    e.rs1_v = v1; e.rs1_vt = f1; e.rs2_v = v2; e.rs2_vt = f2; e.rd = rd; e.aluop = op;
    return e;
  endfunction

  function automatic entry_t rnd_entry();
    logic v1, v2;
    v1 = 1'($urandom_range(0, 1));
    v2 = 1'($urandom_range(0, 1));
    return mk(v1, v1 ? $urandom : 32'($urandom_range(0, 3)),
              v2, v2 ? $urandom : 32'($urandom_range(0, 3)),
              5'($urandom), 5'($urandom));
  endfunction

  task automatic rand_inputs();
    bus.disp0_valid = ($urandom_range(0, 1) == 1);
    bus.disp0_entry = rnd_entry();
    bus.disp1_valid = ($urandom_range(0, 2) == 0);
    bus.disp1_entry = rnd_entry();
    bus.cdb_valid   = ($urandom_range(0, 1) == 1);
    bus.cdb_data    = {$urandom, 5'($urandom_range(0, 3))};
    bus.simple_0_issue = m_busy[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    bus.simple_1_issue = m_busy[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
    if (bus.simple_0_issue && bus.simple_1_issue && $urandom_range(0, 7) != 0)
      bus.simple_1_issue = 1'b0;
`ifdef RS_SIMPLE_FLUSH_EN
    bus.flush = ($urandom_range(0, 29) == 0);
`endif
  endtask

  initial begin
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare();
    rst_n = 1'b1;

    // Single dispatch of a fully ready ADD
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b1, 32'h5, 1'b1, 32'h7, 5'd3, ALU_ADD);
    cycle();
    chk("t2_entry0", bus.rs_simple_0, {32'h7, 1'b1, 32'h5, 1'b1, 5'd3, 5'd0});
    chk("t2_selector", ENTRY_W'(bus.selector), ENTRY_W'(1));
    chk("t2_free", ENTRY_W'(bus.disp_free), ENTRY_W'(1));

    // Waiting rs2 (tag 9) woken by a later broadcast
    idle();
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b1, 32'h1, 1'b0, 32'd9, 5'd4, ALU_SUB);
    cycle();
    idle();
    cycle();
    bus.cdb_valid = 1'b1;
    bus.cdb_data  = {32'hDEADBEEF, 5'd9};
    cycle();
    chk("t3_rs2_value", ENTRY_W'(bus.rs_simple_1[75:44]), ENTRY_W'(32'hDEADBEEF));
    chk("t3_rs2_valid", ENTRY_W'(bus.rs_simple_1[43]), ENTRY_W'(1));
    idle();
    bus.simple_0_issue = 1'b1;
    cycle();
    idle();
    bus.simple_1_issue = 1'b1;
    cycle();
    chk("t3_free_after_issue", ENTRY_W'(bus.disp_free), ENTRY_W'(2));

    // Same-cycle dispatch and broadcast of rs1's producer
    idle();
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b0, 32'd4, 1'b1, 32'h99, 5'd7, ALU_OR);
    bus.cdb_valid   = 1'b1;
    bus.cdb_data    = {32'h1234, 5'd4};
    cycle();
    chk("t4_rs1_valid", ENTRY_W'(bus.rs_simple_0[10]), ENTRY_W'(1));
    chk("t4_rs1_value", ENTRY_W'(bus.rs_simple_0[42:11]), ENTRY_W'(32'h1234));

    // Build entry1-older, then issue entry1 while dispatching into a full station
    idle();
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b1, 32'hB, 1'b1, 32'hB, 5'd8, ALU_AND);
    cycle();
    idle();
    bus.simple_0_issue = 1'b1;
    cycle();
    idle();
    ent_c = mk(1'b1, 32'hC, 1'b1, 32'hC, 5'd9, ALU_XOR);
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = ent_c;
    cycle();
    chk("t5_entry1_older", ENTRY_W'(bus.selector), ENTRY_W'(0));
    idle();
    bus.simple_1_issue = 1'b1;
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b1, 32'hD, 1'b1, 32'hD, 5'd10, ALU_ADD);
    cycle();
    chk("t5_free", ENTRY_W'(bus.disp_free), ENTRY_W'(1));
    chk("t5_selector", ENTRY_W'(bus.selector), ENTRY_W'(1));
    chk("t5_entry1_empty", bus.rs_simple_1, '0);
    chk("t5_entry0_kept", bus.rs_simple_0, ent_c);

    // Randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 800; n++) begin
      rand_inputs();
      if (n == 400) begin
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_entry0", bus.rs_simple_0, '0);
        chk("t1_rst_entry1", bus.rs_simple_1, '0);
        chk("t1_rst_selector", ENTRY_W'(bus.selector), ENTRY_W'(0));
        chk("t1_rst_free", ENTRY_W'(bus.disp_free), ENTRY_W'(2));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
      end else begin
        cycle();
      end
    end

`ifdef RS_SIMPLE_FLUSH_EN
    // Flush beats a same-cycle wakeup, dispatch and issue
    idle();
    bus.simple_0_issue = m_busy[0];
    bus.simple_1_issue = m_busy[1] & ~m_busy[0];
    cycle();
    idle();
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b0, 32'd2, 1'b1, 32'h1, 5'd1, ALU_ADD);
    bus.disp1_valid = 1'b1;
    bus.disp1_entry = mk(1'b1, 32'h3, 1'b0, 32'd2, 5'd2, ALU_SUB);
    cycle();
    idle();
    bus.flush = 1'b1;
    bus.cdb_valid = 1'b1;
    bus.cdb_data = {32'hCAFE, 5'd2};
    bus.disp0_valid = 1'b1;
    bus.disp0_entry = mk(1'b1, 32'h4, 1'b1, 32'h4, 5'd3, ALU_OR);
    bus.simple_0_issue = 1'b1;
    cycle();
    chk("t6_entry0", bus.rs_simple_0, '0);
    chk("t6_entry1", bus.rs_simple_1, '0);
    chk("t6_free", ENTRY_W'(bus.disp_free), ENTRY_W'(2));
`endif

    idle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
